// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch front-end bus: imem request/response, redirect, decode handoff
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  logic                         imem_req_valid;
  logic                         imem_req_ready;
  logic [XLEN-1:0]              imem_req_addr;
  logic                         imem_rsp_valid;
  logic [ILEN-1:0]              imem_rsp_data;
  logic                         redirect_valid;
  logic [XLEN-1:0]              redirect_target;
  logic                         dec_valid;
  logic                         dec_ready;
  logic [ILEN-1:0]              dec_instr;
  logic [XLEN-1:0]              dec_pc;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, occupancy,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target,
           dec_ready
  );

  modport slave (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, occupancy,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target,
           dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with credit-limited prefetch queue
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  fetch_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CW-1:0]   count_q, count_d, outst_q, outst_d, discard_q, discard_d;

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] tag_mem   [DEPTH];

  logic [CW:0] committed;
  logic        req_valid, dec_valid;
  logic        req_fire, rsp_take, push, pop;

  // Credit covers both buffered words and words still in flight, so responses never stall.
  assign committed = {1'b0, count_q} + {1'b0, outst_q};
  assign req_valid = reset && !bus.redirect_valid && (committed < (CW+1)'(DEPTH));
  assign dec_valid = reset && !bus.redirect_valid && (count_q != '0);

  assign req_fire = req_valid && bus.imem_req_ready;
  assign rsp_take = reset && bus.imem_rsp_valid && (outst_q != '0);
  assign push     = rsp_take && !bus.redirect_valid && (discard_q == '0);
  assign pop      = dec_valid && bus.dec_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_take);
    tag_wr_d   = tag_wr_q + AW'(req_fire);
    tag_rd_d   = tag_rd_q + AW'(rsp_take);
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      fetch_pc_d = bus.redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outst_q - CW'(rsp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end
      if (rsp_take && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rsp_data;
      pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
    end
    if (req_fire) begin
      tag_mem[tag_wr_q] <= fetch_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = instr_mem[rd_ptr_q];
  assign bus.dec_pc         = pc_mem[rd_ptr_q];
  assign bus.occupancy      = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed plus random bench for fetch_queue against a queue-based model
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  bit          in_rstn, in_ready, in_dec_ready, in_redir, in_spurious;
  logic [31:0] in_tgt;
  int          lat_min, lat_max;

  typedef struct {
    logic [31:0] addr;
    longint      due;
  } pend_t;
  pend_t  pend[$];
  longint last_due;

  logic [31:0] m_pc;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qins[$];
  logic [31:0] m_tags[$];
  int          m_discard;
  bit          exp_req_valid, exp_dec_valid, rsp_from_mem;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    @(negedge clk);
    reset               = in_rstn;
    bus.imem_req_ready  = in_ready;
    bus.dec_ready       = in_dec_ready;
    bus.redirect_valid  = in_redir;
    bus.redirect_target = in_tgt;
    rsp_from_mem = (pend.size() > 0) && (pend[0].due <= cyc);
    if (rsp_from_mem) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
    end else if (in_spurious) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    exp_req_valid = in_rstn && !in_redir && ((m_qpc.size() + m_tags.size()) < DEPTH);
    exp_dec_valid = in_rstn && !in_redir && (m_qpc.size() != 0);
  endtask

  task automatic commit();
    bit          got;
    logic [31:0] tag;
    longint      due;
    chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_req_valid));
    chk("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
    chk("dec_valid", 64'(bus.dec_valid), 64'(exp_dec_valid));
    if (exp_dec_valid) begin
      chk("dec_pc", 64'(bus.dec_pc), 64'(m_qpc[0]));
      chk("dec_instr", 64'(bus.dec_instr), 64'(m_qins[0]));
    end
    chk("occupancy", 64'(bus.occupancy), 64'(m_qpc.size()));

    if (!in_rstn) begin
      m_pc = RESET_PC;
      m_qpc.delete();
      m_qins.delete();
      m_tags.delete();
      m_discard = 0;
      pend.delete();
      last_due = 0;
    end else begin
      got = (rsp_from_mem || in_spurious) && (m_tags.size() > 0);
      if (rsp_from_mem) void'(pend.pop_front());
      if (got) tag = m_tags.pop_front();
      if (in_redir) begin
        m_pc = in_tgt;
        m_qpc.delete();
        m_qins.delete();
        m_discard = m_tags.size();
      end else begin
        if (exp_dec_valid && in_dec_ready) begin
          void'(m_qpc.pop_front());
          void'(m_qins.pop_front());
        end
        if (got) begin
          if (m_discard > 0) m_discard--;
          else begin
            m_qpc.push_back(tag);
            m_qins.push_back(mem_word(tag));
          end
        end
        if (exp_req_valid && in_ready) begin
          m_tags.push_back(m_pc);
          due = cyc + longint'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          pend.push_back('{addr: m_pc, due: due});
          last_due = due;
          m_pc = m_pc + 32'd1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    commit();
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_target = '0; bus.dec_ready = 1'b0;
    in_rstn = 0; in_ready = 1; in_dec_ready = 1; in_redir = 0; in_spurious = 0;
    in_tgt = '0; lat_min = 1; lat_max = 1; m_pc = RESET_PC; m_discard = 0; last_due = 0;

    repeat (3) step();
    in_rstn = 1;
    drive();
    chk("first_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
    chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    commit();
    repeat (20) begin
      drive();
      chk("occ_le1", 64'(bus.occupancy <= 1), 64'd1);
      commit();
    end

    // Decode stalled: credit must stop issue at exactly DEPTH buffered words.
    in_dec_ready = 0;
    repeat (10) step();
    drive();
    chk("full_occ", 64'(bus.occupancy), 64'(DEPTH));
    chk("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
    commit();
    in_dec_ready = 1;
    step();
    in_dec_ready = 0;
    drive();
    chk("refill_req", 64'(bus.imem_req_valid), 64'd1);
    commit();

    // Redirect with three requests in flight and none returned yet.
    in_rstn = 0; in_dec_ready = 1; lat_min = 4; lat_max = 4;
    step();
    in_rstn = 1;
    repeat (3) step();
    in_redir = 1; in_tgt = 32'h100;
    step();
    in_redir = 0;
    drive();
    chk("redir_addr", 64'(bus.imem_req_addr), 64'h100);
    chk("redir_occ", 64'(bus.occupancy), 64'd0);
    commit();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      drive();
      if (bus.dec_valid === 1'b1) begin
        chk("redir_first_dec_pc", 64'(bus.dec_pc), 64'h100);
        found = 1;
      end
      commit();
    end
    chk("redir_dec_seen", 64'(found), 64'd1);

    // Redirect colliding with a response and a decode handshake.
    lat_min = 2; lat_max = 2;
    repeat (8) step();
    in_redir = 1; in_tgt = 32'h200;
    drive();
    chk("redir_dec_void", 64'(bus.dec_valid), 64'd0);
    chk("redir_req_void", 64'(bus.imem_req_valid), 64'd0);
    commit();
    in_redir = 0;
    drive();
    chk("redir_occ0", 64'(bus.occupancy), 64'd0);
    commit();

    lat_min = 1; lat_max = 1;
    in_dec_ready = 0;
    repeat (6) step();
    in_dec_ready = 1;
    repeat (20) step();

    // PC wrap at the top of the address space, then a mid-stream reset.
    in_redir = 1; in_tgt = 32'hFFFF_FFFF;
    step();
    in_redir = 0;
    drive();
    chk("wrap_pre", 64'(bus.imem_req_addr), 64'hFFFF_FFFF);
    commit();
    drive();
    chk("wrap_addr", 64'(bus.imem_req_addr), 64'h0);
    commit();
    repeat (3) step();
    in_rstn = 0;
    step();
    in_rstn = 1;
    drive();
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
    commit();

    // Response with nothing outstanding must be ignored.
    in_rstn = 0; in_ready = 0;
    step();
    in_rstn = 1;
    step();
    in_spurious = 1;
    step();
    in_spurious = 0;
    drive();
    chk("spurious_occ", 64'(bus.occupancy), 64'd0);
    commit();

    lat_min = 1; lat_max = 5;
    repeat (600) begin
      in_ready     = $urandom_range(0, 3) != 0;
      in_dec_ready = $urandom_range(0, 2) != 0;
      in_redir     = $urandom_range(0, 19) == 0;
      in_tgt       = $urandom;
      in_rstn      = $urandom_range(0, 199) != 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
